// File: rtl/kamikaze_fetch.sv
// kamikaze_fetch: instruction prefetch and RV32IC realignment.
// Whole words are fetched into a small FIFO. The current pc selects a
// halfword of the head word. A 32-bit instruction that starts in the upper
// half of the head word takes its upper 16 bits from the next FIFO entry.
module kamikaze_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, nxt_ptr;
    logic [CW-1:0] fifo_count, outstanding, drop_cnt;
    logic [31:0]   fetch_addr, pc;

    logic [31:0] head;
    logic [15:0] nxt_lo, half;
    logic        half_comp, need_two, out_valid;
    logic [31:0] out_instr;
    logic        grant, push, pop, transfer;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign nxt_ptr = ptr_inc(rd_ptr);
    assign head    = fifo_mem[rd_ptr];
    assign nxt_lo  = fifo_mem[nxt_ptr][15:0];

    // Realignment works on the halfword at pc. The second word is needed
    // only for a 32-bit instruction that starts in the upper half.
    assign half      = pc[1] ? head[31:16] : head[15:0];
    assign half_comp = (half[1:0] != 2'b11);
    assign need_two  = pc[1] && !half_comp;
    assign out_valid = need_two ? (fifo_count >= CW'(2)) : (fifo_count != '0);
    assign out_instr = half_comp ? {16'h0000, half}
                     : (pc[1] ? {nxt_lo, head[31:16]} : head);

    // The data outputs are zeroed when no instruction is available. The
    // gating uses registered state only, so branch_i reaches instr_valid_o alone.
    assign instr_o               = out_valid ? out_instr : '0;
    assign is_compressed_instr_o = out_valid && half_comp;
    assign instr_valid_o         = out_valid && !branch_i;
    assign pc_o                  = pc;

    // Requests are gated by rst_i so that none is issued while reset is held.
    // The room check counts words that are buffered and words that are in flight.
    assign imem_req_o  = rst_i && !branch_i &&
                         (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr_o = fetch_addr;

    assign grant    = imem_req_o && imem_gnt_i;
    assign push     = imem_rvalid_i && (drop_cnt == '0) && !branch_i;
    assign transfer = instr_valid_o && instr_ready_i;
    // Only a compressed instruction in the low half leaves data in the head word.
    assign pop      = transfer && (pc[1] || !half_comp);

    // FIFO storage. Stale contents are harmless because the outputs are gated by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= imem_rdata_i;
        end
    end

    // Fetch control: pointers, counters, pc and the redirect flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_addr  <= BOOT_ADDR;
            pc          <= BOOT_ADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (branch_i) begin
            pc          <= branch_target_i & ~32'h0000_0001;
            fetch_addr  <= branch_target_i & ~32'h0000_0003;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            // No request is issued in a redirect cycle. Every response still
            // pending is stale, including responses already marked for dropping.
            // The drop count is therefore the new outstanding count.
            outstanding <= outstanding - CW'(imem_rvalid_i);
            drop_cnt    <= outstanding - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_addr <= fetch_addr + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            if (imem_rvalid_i && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt_ptr;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (transfer) begin
                pc <= pc + (half_comp ? 32'd2 : 32'd4);
            end
        end
    end

endmodule
